// File: rtl/card_dealer.sv
// Deals cards without replacement from a 52-card deck using an LFSR-driven rank draw.
// Latency: card_valid 2 cycles after req is sampled, at most MAX_TRIES+3 cycles (empty-deck refill plus fallback).
// Backpressure: none; req/shuffle are sampled only when idle and ignored (not queued) while busy.
module card_dealer #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          MAX_TRIES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       shuffle,
    output logic       card_valid,
    output logic [3:0] card_rank,
    output logic [3:0] card_value,
    output logic [5:0] cards_left,
    output logic       deck_empty,
    output logic       busy
);

    // An all-zero seed would lock the LFSR, so it is replaced with 1.
    localparam logic [15:0]   LFSR_INIT   = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0]   LFSR_MASK   = 16'hB400;
    localparam int            TW          = $clog2(MAX_TRIES + 2);
    localparam logic [TW-1:0] TRIES_LIMIT = TW'(MAX_TRIES);

    typedef enum logic [1:0] {IDLE, SHUFFLE, DRAW, DELIVER} state_t;

    state_t           state;
    logic [12:0][2:0] rank_cnt;
    logic [15:0]      lfsr;
    logic [15:0]      lfsr_next;
    logic [TW-1:0]    tries;
    logic             pending;
    logic             dealt;

    logic [3:0]       cand;
    logic             cand_ok;
    logic [3:0]       low_rank;
    logic             low_found;
    logic             fallback;
    logic [3:0]       pick_rank;
    logic             pick_ok;

    // Galois LFSR step (right shift, feedback mask applied when the output bit is 1).
    always_comb begin
        lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
    end

    // Draw selection: random candidate while tries remain, lowest populated rank afterwards.
    always_comb begin
        cand      = lfsr[3:0];
        cand_ok   = 1'b0;
        low_rank  = 4'd0;
        low_found = 1'b0;
        for (int i = 12; i >= 0; i--) begin
            if (rank_cnt[i] != 3'd0) begin
                low_rank  = 4'(i);
                low_found = 1'b1;
            end
        end
        for (int i = 0; i < 13; i++) begin
            if (cand == 4'(i) && rank_cnt[i] != 3'd0) begin
                cand_ok = 1'b1;
            end
        end
        fallback  = (tries >= TRIES_LIMIT);
        pick_rank = fallback ? low_rank : cand;
        pick_ok   = fallback ? low_found : cand_ok;
    end

    // Blackjack value of the latched rank; reads 0 until the first card has been dealt.
    always_comb begin
        if (!dealt) begin
            card_value = 4'd0;
        end else if (card_rank == 4'd0) begin
            card_value = 4'd11;
        end else if (card_rank <= 4'd9) begin
            card_value = card_rank + 4'd1;
        end else begin
            card_value = 4'd10;
        end
    end

    assign deck_empty = (cards_left == 6'd0);

    // Main FSM with deck bookkeeping and registered strobe/busy outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rank_cnt   <= {13{3'd4}};
            cards_left <= 6'd52;
            lfsr       <= LFSR_INIT;
            tries      <= '0;
            pending    <= 1'b0;
            dealt      <= 1'b0;
            card_valid <= 1'b0;
            card_rank  <= 4'd0;
            busy       <= 1'b0;
        end else begin
            lfsr       <= lfsr_next;
            card_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (shuffle) begin
                        state   <= SHUFFLE;
                        pending <= 1'b0;
                        busy    <= 1'b1;
                    end else if (req) begin
                        busy <= 1'b1;
                        if (cards_left != 6'd0) begin
                            state <= DRAW;
                            tries <= '0;
                        end else begin
                            state   <= SHUFFLE;
                            pending <= 1'b1;
                        end
                    end
                end
                SHUFFLE: begin
                    rank_cnt   <= {13{3'd4}};
                    cards_left <= 6'd52;
                    pending    <= 1'b0;
                    if (pending) begin
                        state <= DRAW;
                        tries <= '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                DRAW: begin
                    if (pick_ok && cards_left != 6'd0) begin
                        for (int i = 0; i < 13; i++) begin
                            if (pick_rank == 4'(i)) begin
                                rank_cnt[i] <= rank_cnt[i] - 3'd1;
                            end
                        end
                        cards_left <= cards_left - 6'd1;
                        card_rank  <= pick_rank;
                        dealt      <= 1'b1;
                        card_valid <= 1'b1;
                        state      <= DELIVER;
                    end else begin
                        tries <= tries + TW'(1);
                    end
                end
                DELIVER: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: reset/shuffle vector table, randomized dealing against a deck model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_card_dealer;

    localparam int MT = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic       shuffle = 1'b0;
    logic       card_valid;
    logic [3:0] card_rank;
    logic [3:0] card_value;
    logic [5:0] cards_left;
    logic       deck_empty;
    logic       busy;

    always #5 clk = ~clk;

    card_dealer #(
        .SEED      (16'hACE1),
        .MAX_TRIES (MT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .shuffle    (shuffle),
        .card_valid (card_valid),
        .card_rank  (card_rank),
        .card_value (card_value),
        .cards_left (cards_left),
        .deck_empty (deck_empty),
        .busy       (busy)
    );

    typedef struct {
        bit rst;
        bit req;
        bit shf;
        bit e_busy;
        bit e_valid;
        int e_left;
        bit e_empty;
    } vec_t;

    vec_t tab[10];

    int n_checks = 0;
    int n_pass   = 0;
    int mcount[13];
    int mleft;
    int tally[13];
    int seq_cur[8];
    int seq_a[8];
    int seq_b[8];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_value(input int r);
        if (r == 0) return 11;
        if (r <= 9) return r + 1;
        return 10;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 13; i++) mcount[i] = 4;
        mleft = 52;
    endtask

    task automatic clear_tally();
        for (int i = 0; i < 13; i++) tally[i] = 0;
    endtask

    // Request one card; with junk set, req (and random shuffle) are held during the busy window.
    task automatic deal_one(input bit junk, output int rank);
        int lat;
        bit got;
        rank = -1;
        got  = 1'b0;
        if (mleft == 0) model_reset();
        req     = 1'b1;
        shuffle = 1'b0;
        tick();
        req = 1'b0;
        lat = 1;
        while (!got && lat <= MT + 4) begin
            if (card_valid) begin
                got = 1'b1;
            end else begin
                if (junk) begin
                    req     = 1'b1;
                    shuffle = 1'($urandom % 2);
                end
                tick();
                lat++;
            end
        end
        req     = 1'b0;
        shuffle = 1'b0;
        check("deal_timeout", int'(got), 1);
        if (got) begin
            check("latency_in_range", int'(lat >= 2 && lat <= MT + 3), 1);
            rank = int'(card_rank);
            check("rank_range", int'(card_rank <= 4'd12), 1);
            if (card_rank <= 4'd12) begin
                check("rank_available", int'(mcount[card_rank] > 0), 1);
                if (mcount[card_rank] > 0) begin
                    mcount[card_rank]--;
                    mleft--;
                end
                tally[card_rank]++;
                check("card_value", int'(card_value), exp_value(int'(card_rank)));
            end
            check("cards_left", int'(cards_left), mleft);
            check("deck_empty", int'(deck_empty), int'(mleft == 0));
            tick();
            check("strobe_one_cycle", int'(card_valid), 0);
            check("idle_after_deal", int'(busy), 0);
        end
    endtask

    task automatic run_seq();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            repeat (i % 3) tick();
            deal_one(1'b0, seq_cur[i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        int nv;

        // rst req shf | busy valid left empty
        tab[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 52, 1'b0};
        tab[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 52, 1'b0};
        tab[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 52, 1'b0};
        tab[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 52, 1'b0};
        tab[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 52, 1'b0};
        tab[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 52, 1'b0};
        tab[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 52, 1'b0};
        tab[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 52, 1'b0};
        tab[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 52, 1'b0};
        tab[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 52, 1'b0};

        for (int i = 0; i < 10; i++) begin
            rst     = tab[i].rst;
            req     = tab[i].req;
            shuffle = tab[i].shf;
            tick();
            check($sformatf("tab%0d_busy", i),  int'(busy),       int'(tab[i].e_busy));
            check($sformatf("tab%0d_valid", i), int'(card_valid), int'(tab[i].e_valid));
            check($sformatf("tab%0d_left", i),  int'(cards_left), tab[i].e_left);
            check($sformatf("tab%0d_empty", i), int'(deck_empty), int'(tab[i].e_empty));
        end
        check("reset_card_value", int'(card_value), 0);
        req     = 1'b0;
        shuffle = 1'b0;

        // Full deck: 52 randomized deals, each rank exactly four times.
        model_reset();
        clear_tally();
        for (int i = 0; i < 52; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            deal_one(1'b1, r);
        end
        check("empty_left", int'(cards_left), 0);
        check("empty_flag", int'(deck_empty), 1);
        for (int k = 0; k < 13; k++) check($sformatf("tally_rank%0d", k), tally[k], 4);

        // Request on an empty deck refills then deals.
        deal_one(1'b1, r);
        check("refill_left", int'(cards_left), 51);
        check("refill_empty", int'(deck_empty), 0);
        for (int i = 0; i < 9; i++) deal_one(1'b1, r);
        check("ten_dealt_left", int'(cards_left), 42);

        // shuffle wins over req in the same idle cycle.
        req     = 1'b1;
        shuffle = 1'b1;
        tick();
        req     = 1'b0;
        shuffle = 1'b0;
        check("shuffle_busy", int'(busy), 1);
        tick();
        check("shuffle_left", int'(cards_left), 52);
        model_reset();
        nv = 0;
        for (int i = 0; i < 6; i++) begin
            if (card_valid) nv++;
            tick();
        end
        check("shuffle_no_card", nv, 0);
        check("shuffle_idle", int'(busy), 0);

        // req held during the draw must not produce a second card.
        deal_one(1'b1, r);
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            if (card_valid) nv++;
            tick();
        end
        check("no_second_card", nv, 0);

        // Reset in the middle of a draw.
        req = 1'b1;
        tick();
        req = 1'b0;
        check("draw_busy", int'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_draw_valid", int'(card_valid), 0);
        check("rst_draw_left", int'(cards_left), 52);
        check("rst_draw_busy", int'(busy), 0);
        check("rst_draw_value", int'(card_value), 0);
        tick();
        check("rst_next_valid", int'(card_valid), 0);
        model_reset();

        // Identical timing after reset reproduces the same card sequence.
        run_seq();
        for (int i = 0; i < 8; i++) seq_a[i] = seq_cur[i];
        run_seq();
        for (int i = 0; i < 8; i++) seq_b[i] = seq_cur[i];
        for (int i = 0; i < 8; i++) check($sformatf("repro_card%0d", i), seq_b[i], seq_a[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
